// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART: register offsets, STATUS bit
// positions, access-size codes, FSM encodings and the baud divider floor.
`timescale 1ns/1ps
package uart_pkg;

    localparam logic [7:0] OFF_TXDATA  = 8'h00;
    localparam logic [7:0] OFF_RXDATA  = 8'h04;
    localparam logic [7:0] OFF_STATUS  = 8'h08;
    localparam logic [7:0] OFF_BAUDDIV = 8'h0C;
    localparam logic [7:0] OFF_IE      = 8'h14;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_TX_BUSY     = 2;
    localparam int ST_RX_VALID    = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;
    localparam int ST_FRAME_ERR   = 6;

    typedef enum logic [1:0] {
        HB_BYTE = 2'b00,
        HB_HALF = 2'b01,
        HB_WORD = 2'b10
    } hb_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_e;

    localparam logic [15:0] BAUD_MIN = 16'd3;

    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < BAUD_MIN) ? BAUD_MIN : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead head output; a push while full is dropped
// even when a pop happens on the same edge.
`timescale 1ns/1ps
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == CW'(0));
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage array
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= wdata_i;
    end

endmodule

// File: rtl/uart_responder.sv
// Memory-mapped 8N1 UART with TX FIFO, serializer, deserializer and status.
// Define UART_RESPONDER_IRQ_EN to add the IE register at 0x14 and a live irq_o.
`timescale 1ns/1ps
module uart_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cs_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [1:0]  hb_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        irq_o
);
    logic [15:0] r_baud;
    logic        r_rx_valid, r_rx_overrun, r_tx_overflow, r_frame_err;
    logic [7:0]  r_rx_byte;

    logic [7:0]  w_off;
    logic        w_wr, w_wr_tx, w_wr_st, w_wr_baud;
    logic        w_fifo_full, w_fifo_empty, w_pop;
    logic [7:0]  w_fifo_head;
    logic [$clog2(TX_FIFO_DEPTH):0] w_fifo_count;
    logic [31:0] w_status, w_rdata;
    logic        w_unused;

    assign w_off     = {addr_i[7:2], 2'b00};
    assign w_wr      = cs_i & we_i;
    assign w_wr_tx   = w_wr & (w_off == OFF_TXDATA);
    assign w_wr_st   = w_wr & (w_off == OFF_STATUS);
    assign w_wr_baud = w_wr & (w_off == OFF_BAUDDIV);
    assign w_unused  = ^{hb_i, addr_i[31:8], addr_i[1:0], wdata_i, w_fifo_count};

    uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_wr_tx),
        .pop_i   (w_pop),
        .wdata_i (wdata_i[7:0]),
        .rdata_o (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    tx_state_e   r_tx_state, w_tx_state_n;
    logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_shift, w_tx_shift_n;
    logic        r_tx, w_tx_n, w_tx_end;

    assign w_tx_end = (r_tx_cnt == r_tx_div);

    // TX next-state: the divider is re-latched at every bit boundary
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt + 16'd1;
        w_tx_div_n   = r_tx_div;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_n       = r_tx;
        w_pop        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_n = 16'd0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_tx_state_n = TX_START;
                    w_tx_shift_n = w_fifo_head;
                    w_tx_div_n   = eff_div(r_baud);
                    w_tx_n       = 1'b0;
                end else begin
                    w_tx_n = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_end) begin
                    w_tx_state_n = TX_DATA;
                    w_tx_cnt_n   = 16'd0;
                    w_tx_bit_n   = 3'd0;
                    w_tx_div_n   = eff_div(r_baud);
                    w_tx_n       = r_tx_shift[0];
                end else begin
                    w_tx_n = 1'b0;
                end
            end
            TX_DATA: begin
                if (w_tx_end) begin
                    w_tx_cnt_n = 16'd0;
                    w_tx_div_n = eff_div(r_baud);
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                        w_tx_n       = 1'b1;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                        w_tx_n       = r_tx_shift[1];
                    end
                end else begin
                    w_tx_n = r_tx;
                end
            end
            TX_STOP: begin
                if (w_tx_end) begin
                    w_tx_cnt_n = 16'd0;
                    w_tx_div_n = eff_div(r_baud);
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_tx_state_n = TX_START;
                        w_tx_shift_n = w_fifo_head;
                        w_tx_n       = 1'b0;
                    end else begin
                        w_tx_state_n = TX_IDLE;
                        w_tx_n       = 1'b1;
                    end
                end else begin
                    w_tx_n = 1'b1;
                end
            end
            default: begin
                w_tx_state_n = TX_IDLE;
                w_tx_n       = 1'b1;
            end
        endcase
    end

    // TX state and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_div   <= BAUD_MIN;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_div   <= w_tx_div_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx       <= w_tx_n;
        end
    end

    assign uart_tx_o = r_tx;

    rx_state_e   r_rx_state, w_rx_state_n;
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n, w_rx_half_m1;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_shift, w_rx_shift_n;
    logic        w_rx_set_valid, w_rx_set_ferr;

    assign w_rx_half_m1 = 16'(({1'b0, r_rx_div} + 17'd1) >> 1) - 16'd1;

    // RX next-state: start is a falling edge, so a line stuck low after a bad stop is ignored
    always_comb begin
        w_rx_state_n   = r_rx_state;
        w_rx_cnt_n     = r_rx_cnt + 16'd1;
        w_rx_div_n     = r_rx_div;
        w_rx_bit_n     = r_rx_bit;
        w_rx_shift_n   = r_rx_shift;
        w_rx_set_valid = 1'b0;
        w_rx_set_ferr  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_n = 16'd0;
                if (r_rx_s3 & ~r_rx_s2) begin
                    w_rx_state_n = RX_START;
                    w_rx_div_n   = eff_div(r_baud);
                end else begin
                    w_rx_state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (r_rx_cnt == w_rx_half_m1) begin
                    w_rx_cnt_n   = 16'd0;
                    w_rx_bit_n   = 3'd0;
                    w_rx_div_n   = eff_div(r_baud);
                    w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_state_n = RX_START;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == r_rx_div) begin
                    w_rx_cnt_n   = 16'd0;
                    w_rx_div_n   = eff_div(r_baud);
                    w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_bit_n   = r_rx_bit + 3'd1;
                    w_rx_state_n = (r_rx_bit == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    w_rx_state_n = RX_DATA;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == r_rx_div) begin
                    w_rx_state_n   = RX_IDLE;
                    w_rx_set_valid = r_rx_s2;
                    w_rx_set_ferr  = ~r_rx_s2;
                end else begin
                    w_rx_state_n = RX_STOP;
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    // RX synchronizer, state and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_div   <= BAUD_MIN;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            r_rx_s1    <= uart_rx_i;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_div   <= w_rx_div_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    // Control and sticky status registers; a same-cycle set beats a W1C
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_baud        <= 16'(CLKS_PER_BIT - 1);
            r_rx_byte     <= 8'd0;
            r_rx_valid    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_overflow <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            if (w_wr_baud) r_baud <= wdata_i[15:0];
            if (w_rx_set_valid) r_rx_byte <= r_rx_shift;
            r_rx_valid    <= w_rx_set_valid |
                             (r_rx_valid & ~(w_wr_st & wdata_i[ST_RX_VALID]));
            r_rx_overrun  <= (w_rx_set_valid & r_rx_valid) |
                             (r_rx_overrun & ~(w_wr_st & wdata_i[ST_RX_OVERRUN]));
            r_tx_overflow <= (w_wr_tx & w_fifo_full) |
                             (r_tx_overflow & ~(w_wr_st & wdata_i[ST_TX_OVERFLOW]));
            r_frame_err   <= w_rx_set_ferr |
                             (r_frame_err & ~(w_wr_st & wdata_i[ST_FRAME_ERR]));
        end
    end

    // STATUS word assembly
    always_comb begin
        w_status                 = 32'd0;
        w_status[ST_TX_FULL]     = w_fifo_full;
        w_status[ST_TX_EMPTY]    = w_fifo_empty;
        w_status[ST_TX_BUSY]     = (r_tx_state != TX_IDLE);
        w_status[ST_RX_VALID]    = r_rx_valid;
        w_status[ST_RX_OVERRUN]  = r_rx_overrun;
        w_status[ST_TX_OVERFLOW] = r_tx_overflow;
        w_status[ST_FRAME_ERR]   = r_frame_err;
    end

`ifdef UART_RESPONDER_IRQ_EN
    logic [1:0] r_ie;
    logic       r_irq;

    // Interrupt enable register and registered interrupt line
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ie  <= 2'b00;
            r_irq <= 1'b0;
        end else begin
            if (w_wr & (w_off == OFF_IE)) r_ie <= wdata_i[1:0];
            r_irq <= (r_rx_valid & r_ie[0]) |
                     (w_fifo_empty & (r_tx_state == TX_IDLE) & r_ie[1]);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    // Zero-wait-state read decode
    always_comb begin
        w_rdata = 32'd0;
        if (cs_i) begin
            case (w_off)
                OFF_RXDATA:  w_rdata = {24'd0, r_rx_byte};
                OFF_STATUS:  w_rdata = w_status;
                OFF_BAUDDIV: w_rdata = {16'd0, r_baud};
`ifdef UART_RESPONDER_IRQ_EN
                OFF_IE:      w_rdata = {30'd0, r_ie};
`endif
                default:     w_rdata = 32'd0;
            endcase
        end else begin
            w_rdata = 32'd0;
        end
    end

    assign rdata_o = w_rdata;

endmodule
